// File: rtl/debug_pkg.sv
// Shared debug-controller types: host opcodes, halt cause codes and state encodings.
// Imported by the controller, the host-side decoder and the bench.
package debug_pkg;

  localparam int unsigned CAUSE_W = 3;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'b00,
    OP_RESUME = 2'b01,
    OP_STEP   = 2'b10,
    OP_RSVD   = 2'b11
  } dbg_op_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_SYSTEM   = 3'd1,
    CAUSE_MIS_PC   = 3'd2,
    CAUSE_MIS_ADDR = 3'd3,
    CAUSE_STEP     = 3'd4
  } halt_cause_e;

  // Status readout; both single-cycle unhalt states report DS_UNHALT
  typedef enum logic [1:0] {
    DS_RUN      = 2'd0,
    DS_HALTED   = 2'd1,
    DS_UNHALT   = 2'd2,
    DS_STEPPING = 2'd3
  } dbg_state_e;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_HALTED   = 3'd1,
    ST_RESUMING = 3'd2,
    ST_STEP_GO  = 3'd3,
    ST_STEPPING = 3'd4
  } fsm_state_e;

  function automatic dbg_state_e status_of(fsm_state_e s);
    case (s)
      ST_HALTED:               return DS_HALTED;
      ST_RESUMING, ST_STEP_GO: return DS_UNHALT;
      ST_STEPPING:             return DS_STEPPING;
      default:                 return DS_RUN;
    endcase
  endfunction

endpackage

// File: rtl/debug_ctrl.sv
// Debug/run controller: records halt cause/PC, counts halts, and serves resume/step
// commands from the host, pulsing unhalt into the halt register.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               halted,
  input  logic               system,
  input  logic               misaligned_pc,
  input  logic               misaligned_addr,
  input  logic               mem_en,
  input  logic               retire,
  input  logic [XLEN-1:0]    pc,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  output logic               cmd_ready,
  output logic               unhalt,
  output logic               step_halt,
  output logic [CAUSE_W-1:0] cause,
  output logic [XLEN-1:0]    cause_pc,
  output logic [COUNT_W-1:0] halt_count,
  output logic [1:0]         state
);

  fsm_state_e         state_q, state_d;
  halt_cause_e        cause_q, cause_d;
  logic [XLEN-1:0]    cause_pc_q, cause_pc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] count_sat;

  dbg_op_e     op;
  halt_cause_e hit_cause;
  logic        hit;
  logic        capture_state;

  assign op            = dbg_op_e'(cmd_op);
  assign hit           = system | misaligned_pc | (mem_en & misaligned_addr);
  assign capture_state = (state_q == ST_RUN) || (state_q == ST_STEPPING);
  assign count_sat     = (count_q == '1) ? count_q : count_q + COUNT_W'(1);

  always_comb begin
    hit_cause = CAUSE_SYSTEM;
    if (misaligned_pc) begin
      hit_cause = CAUSE_MIS_PC;
    end else if (mem_en && misaligned_addr) begin
      hit_cause = CAUSE_MIS_ADDR;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    cause_pc_d = cause_pc_q;
    count_d    = count_q;

    // A real cause on the retire cycle outranks the step cause
    if (capture_state && !halted) begin
      if (hit) begin
        cause_d    = hit_cause;
        cause_pc_d = pc;
      end else if ((state_q == ST_STEPPING) && retire) begin
        cause_d    = CAUSE_STEP;
        cause_pc_d = pc;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (halted) begin
          state_d = ST_HALTED;
          count_d = count_sat;
        end
      end
      ST_HALTED: begin
        if (cmd_valid) begin
          case (op)
            OP_CLEAR: begin
              cause_d    = CAUSE_NONE;
              cause_pc_d = '0;
              count_d    = '0;
            end
            OP_RESUME: state_d = ST_RESUMING;
            OP_STEP:   state_d = ST_STEP_GO;
            default:   state_d = ST_HALTED;
          endcase
        end
      end
      ST_RESUMING: state_d = ST_RUN;
      ST_STEP_GO:  state_d = ST_STEPPING;
      ST_STEPPING: begin
        if (halted) begin
          state_d = ST_HALTED;
          count_d = count_sat;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      cause_q    <= CAUSE_NONE;
      cause_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cause_pc_q <= cause_pc_d;
      count_q    <= count_d;
    end
  end

  assign cmd_ready  = (state_q == ST_HALTED);
  assign unhalt     = (state_q == ST_RESUMING) || (state_q == ST_STEP_GO);
  assign step_halt  = (state_q == ST_STEPPING) && retire;
  assign cause      = cause_q;
  assign cause_pc   = cause_pc_q;
  assign halt_count = count_q;
  assign state      = status_of(state_q);

endmodule

// File: tb/tb_debug_ctrl.sv
// Scoreboard bench for debug_ctrl with a behavioural halt register in the loop.
module tb_debug_ctrl;
  import debug_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned COUNT_W = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               halted;
  logic               system, misaligned_pc, misaligned_addr, mem_en, retire;
  logic [XLEN-1:0]    pc;
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic               cmd_ready, unhalt, step_halt;
  logic [CAUSE_W-1:0] cause;
  logic [XLEN-1:0]    cause_pc;
  logic [COUNT_W-1:0] halt_count;
  logic [1:0]         state;

  always #5 clk = ~clk;

  debug_ctrl #(.XLEN(XLEN), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .halted(halted), .system(system),
    .misaligned_pc(misaligned_pc), .misaligned_addr(misaligned_addr), .mem_en(mem_en),
    .retire(retire), .pc(pc), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .unhalt(unhalt), .step_halt(step_halt), .cause(cause),
    .cause_pc(cause_pc), .halt_count(halt_count), .state(state)
  );

  // Halt register: sets on any cause or step_halt, cleared by unhalt
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      halted <= 1'b0;
    else if (unhalt)
      halted <= 1'b0;
    else if (system | misaligned_pc | (mem_en & misaligned_addr) | step_halt)
      halted <= 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    pc;
    logic [COUNT_W-1:0] cnt;
  } halt_rec_t;

  halt_rec_t halt_q[$];
  int        unhalt_q[$];
  int        step_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a halt entry, unhalt or step_halt
  logic      prev_ready = 1'b0;
  halt_rec_t r;
  int        e;
  always @(negedge clk) begin
    if (reset_n) begin
      if (cmd_ready && !prev_ready) begin
        if (halt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL halt_entry: unexpected halt at cycle %0d, required none", cyc);
        end else begin
          r = halt_q.pop_front();
          chk("halt_cause", 64'(cause), 64'(r.cause));
          chk("halt_cause_pc", 64'(cause_pc), 64'(r.pc));
          chk("halt_count", 64'(halt_count), 64'(r.cnt));
        end
      end
      if (unhalt) begin
        if (unhalt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unhalt: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          e = unhalt_q.pop_front();
          chk("unhalt_cycle", 64'(cyc), 64'(e));
        end
        chk("unhalt_state", 64'(state), 64'(DS_UNHALT));
      end
      if (step_halt) begin
        if (step_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL step_halt: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          e = step_q.pop_front();
          chk("step_halt_cycle", 64'(cyc), 64'(e));
        end
        chk("step_halt_state", 64'(state), 64'(DS_STEPPING));
      end
    end
    prev_ready = cmd_ready;
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step_cyc();
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL %s: timeout, cmd_ready=%0b required 1", name, cmd_ready);
    end
  endtask

  // One-cycle cause pulse, then wait for HALTED; expectation is hand-supplied
  task automatic halt_on(input logic sys, input logic mpc, input logic men, input logic maddr,
                         input logic [XLEN-1:0] at_pc, input logic [CAUSE_W-1:0] exp_cause,
                         input logic [COUNT_W-1:0] exp_cnt);
    system = sys; misaligned_pc = mpc; mem_en = men; misaligned_addr = maddr; pc = at_pc;
    halt_q.push_back('{cause: exp_cause, pc: at_pc, cnt: exp_cnt});
    step_cyc();
    system = 1'b0; misaligned_pc = 1'b0; mem_en = 1'b0; misaligned_addr = 1'b0;
    wait_halted("halt_wait");
    chk("halted_state", 64'(state), 64'(DS_HALTED));
  endtask

  // Issue a command in a HALTED cycle; unhalt expected on the following cycle
  task automatic issue(input dbg_op_e op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    if (op == OP_RESUME || op == OP_STEP) unhalt_q.push_back(cyc + 1);
    step_cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [COUNT_W-1:0] SAT_CNT [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    int c0;
    reset_n = 1'b0;
    system = 1'b0; misaligned_pc = 1'b0; misaligned_addr = 1'b0; mem_en = 1'b0;
    retire = 1'b0; pc = '0; cmd_valid = 1'b0; cmd_op = OP_CLEAR;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'(state), 64'(DS_RUN));
    chk("rst_cause", 64'(cause), 64'(CAUSE_NONE));
    chk("rst_cause_pc", 64'(cause_pc), 64'h0);
    chk("rst_count", 64'(halt_count), 64'h0);
    chk("rst_unhalt", 64'(unhalt), 64'h0);
    chk("rst_step_halt", 64'(step_halt), 64'h0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
    reset_n = 1'b1;
    step_cyc();

    // system halt, then resume latency
    halt_on(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, CAUSE_SYSTEM, 2'd1);
    issue(OP_RESUME);
    step_cyc();
    chk("resume_state", 64'(state), 64'(DS_RUN));
    chk("resume_halted", 64'(halted), 64'h0);

    // MIS_PC beats SYSTEM
    halt_on(1'b1, 1'b1, 1'b0, 1'b0, 32'h202, CAUSE_MIS_PC, 2'd2);
    issue(OP_RESUME);
    step_cyc();
    // unqualified misaligned_addr must not capture or halt
    misaligned_addr = 1'b1; pc = 32'h2f0;
    repeat (3) step_cyc();
    misaligned_addr = 1'b0;
    chk("noqual_state", 64'(state), 64'(DS_RUN));
    chk("noqual_halted", 64'(halted), 64'h0);
    chk("noqual_cause", 64'(cause), 64'(CAUSE_MIS_PC));
    chk("noqual_cause_pc", 64'(cause_pc), 64'h202);

    // MIS_ADDR beats SYSTEM
    halt_on(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, CAUSE_MIS_ADDR, 2'd3);
    issue(OP_CLEAR);
    chk("clear_cause", 64'(cause), 64'(CAUSE_NONE));
    chk("clear_cause_pc", 64'(cause_pc), 64'h0);
    chk("clear_count", 64'(halt_count), 64'h0);
    chk("clear_state", 64'(state), 64'(DS_HALTED));
    issue(OP_RSVD);
    chk("rsvd_state", 64'(state), 64'(DS_HALTED));
    chk("rsvd_cmd_ready", 64'(cmd_ready), 64'h1);

    // single step: retire three cycles after the command
    issue(OP_STEP);
    chk("stepgo_state", 64'(state), 64'(DS_UNHALT));
    step_cyc();
    chk("stepping_state", 64'(state), 64'(DS_STEPPING));
    chk("stepping_no_step_halt", 64'(step_halt), 64'h0);
    step_cyc();
    retire = 1'b1; pc = 32'h104;
    step_q.push_back(cyc);
    halt_q.push_back('{cause: CAUSE_STEP, pc: 32'h104, cnt: 2'd1});
    step_cyc();
    retire = 1'b0;
    wait_halted("step_wait");

    // step without retire lingers; then a real cause on the retire cycle wins
    issue(OP_STEP);
    step_cyc();
    repeat (4) step_cyc();
    chk("step_linger_state", 64'(state), 64'(DS_STEPPING));
    retire = 1'b1; system = 1'b1; pc = 32'h108;
    step_q.push_back(cyc);
    halt_q.push_back('{cause: CAUSE_SYSTEM, pc: 32'h108, cnt: 2'd2});
    step_cyc();
    retire = 1'b0; system = 1'b0;
    wait_halted("step_sys_wait");

    // command held while running stalls until HALTED
    issue(OP_RESUME);
    step_cyc();
    cmd_valid = 1'b1; cmd_op = OP_RESUME;
    repeat (4) begin
      step_cyc();
      chk("stall_cmd_ready", 64'(cmd_ready), 64'h0);
    end
    system = 1'b1; pc = 32'h400;
    c0 = cyc;
    halt_q.push_back('{cause: CAUSE_SYSTEM, pc: 32'h400, cnt: 2'd3});
    unhalt_q.push_back(c0 + 3);
    step_cyc();
    system = 1'b0;
    step_cyc();
    chk("stall_accept_ready", 64'(cmd_ready), 64'h1);
    step_cyc();
    cmd_valid = 1'b0;
    step_cyc();
    chk("stall_resume_state", 64'(state), 64'(DS_RUN));
    chk("stall_resume_halted", 64'(halted), 64'h0);

    // reset asserted in the middle of STEPPING
    halt_on(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, CAUSE_SYSTEM, 2'd3);
    issue(OP_STEP);
    step_cyc();
    chk("pre_rst_state", 64'(state), 64'(DS_STEPPING));
    retire = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("midstep_rst_state", 64'(state), 64'(DS_RUN));
    chk("midstep_rst_cause", 64'(cause), 64'(CAUSE_NONE));
    chk("midstep_rst_cause_pc", 64'(cause_pc), 64'h0);
    chk("midstep_rst_count", 64'(halt_count), 64'h0);
    chk("midstep_rst_unhalt", 64'(unhalt), 64'h0);
    chk("midstep_rst_step_halt", 64'(step_halt), 64'h0);
    step_cyc();
    retire = 1'b0;
    reset_n = 1'b1;
    step_cyc();

    // saturation with COUNT_W=2 over five rounds
    for (int i = 0; i < 5; i++) begin
      halt_on(1'b1, 1'b0, 1'b0, 1'b0, 32'h600 + 32'(4 * i), CAUSE_SYSTEM, SAT_CNT[i]);
      issue(OP_RESUME);
      step_cyc();
    end
    chk("sat_count", 64'(halt_count), 64'h3);
    halt_on(1'b0, 1'b1, 1'b0, 1'b0, 32'h702, CAUSE_MIS_PC, 2'd3);
    issue(OP_CLEAR);
    chk("sat_clear_count", 64'(halt_count), 64'h0);
    chk("sat_clear_cause", 64'(cause), 64'(CAUSE_NONE));
    chk("sat_clear_cause_pc", 64'(cause_pc), 64'h0);

    repeat (2) step_cyc();
    chk("drain_halt_q", 64'(halt_q.size()), 64'h0);
    chk("drain_unhalt_q", 64'(unhalt_q.size()), 64'h0);
    chk("drain_step_q", 64'(step_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
